// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle between issue logic, fp_mul_pipe and writeback.
// The master side issues operands and accepts results; the multiplier is the slave.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, rnd_mode, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, rnd_mode, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with RNE/RTZ rounding, FTZ inputs and
// exception flags {invalid, overflow, underflow, inexact}; the whole pipe stalls as one.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_pipe_if.slave bus
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int E_W    = EXP_W + 2;

    localparam logic signed [E_W-1:0] BIAS   = E_W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ZERO = '0;
    localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    logic adv;
    assign adv = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

    // ---------------- Stage 1: unpack, classify, exponent sum ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    assign {sa, ea, fa} = bus.a;
    assign {sb, eb, fb} = bus.b;

    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];

    logic                    sign_c;
    logic signed [E_W-1:0]   exp_c;
    logic                    spec_c;
    logic [W-1:0]            spec_res_c;
    logic [3:0]              spec_flags_c;

    assign sign_c = sa ^ sb;
    assign exp_c  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    // Special operands resolve here and ride the pipe unchanged past rounding.
    always_comb begin
        spec_c       = 1'b0;
        spec_res_c   = '0;
        spec_flags_c = '0;
        if (a_nan || b_nan) begin
            spec_c       = 1'b1;
            spec_res_c   = QNAN;
            spec_flags_c = {a_snan | b_snan, 3'b000};
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_c       = 1'b1;
            spec_res_c   = QNAN;
            spec_flags_c = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_c     = 1'b1;
            spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_c     = 1'b1;
            spec_res_c = {sign_c, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end
    end

    logic                  s1_valid, s1_sign, s1_rnd, s1_spec;
    logic signed [E_W-1:0] s1_exp;
    logic [SIG_W-1:0]      s1_sig_a, s1_sig_b;
    logic [W-1:0]          s1_spec_res;
    logic [3:0]            s1_spec_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_rnd        <= 1'b0;
            s1_spec       <= 1'b0;
            s1_exp        <= '0;
            s1_sig_a      <= '0;
            s1_sig_b      <= '0;
            s1_spec_res   <= '0;
            s1_spec_flags <= '0;
        end else if (adv) begin
            s1_valid      <= bus.in_valid;
            s1_sign       <= sign_c;
            s1_rnd        <= bus.rnd_mode;
            s1_spec       <= spec_c;
            s1_exp        <= exp_c;
            s1_sig_a      <= {1'b1, fa};
            s1_sig_b      <= {1'b1, fb};
            s1_spec_res   <= spec_res_c;
            s1_spec_flags <= spec_flags_c;
        end
    end

    // ---------------- Stage 2: significand product ----------------
    logic [PROD_W-1:0] prod_c;
    assign prod_c = {{SIG_W{1'b0}}, s1_sig_a} * {{SIG_W{1'b0}}, s1_sig_b};

    logic                  s2_valid, s2_sign, s2_rnd, s2_spec;
    logic signed [E_W-1:0] s2_exp;
    logic [PROD_W-1:0]     s2_prod;
    logic [W-1:0]          s2_spec_res;
    logic [3:0]            s2_spec_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid      <= 1'b0;
            s2_sign       <= 1'b0;
            s2_rnd        <= 1'b0;
            s2_spec       <= 1'b0;
            s2_exp        <= '0;
            s2_prod       <= '0;
            s2_spec_res   <= '0;
            s2_spec_flags <= '0;
        end else if (adv) begin
            s2_valid      <= s1_valid;
            s2_sign       <= s1_sign;
            s2_rnd        <= s1_rnd;
            s2_spec       <= s1_spec;
            s2_exp        <= s1_exp;
            s2_prod       <= prod_c;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
        end
    end

    // ---------------- Stage 3: normalise, round, range check ----------------
    logic [MAN_W-1:0]      frac_t, frac_fin;
    logic                  guard, sticky, inc;
    logic [MAN_W:0]        rounded;
    logic signed [E_W-1:0] e_norm, e_fin;
    logic [W-1:0]          res_c;
    logic [3:0]            flags_c;

    // A product in [2,4) is read one bit higher instead of physically shifting it.
    always_comb begin
        if (s2_prod[PROD_W-1]) begin
            frac_t = s2_prod[PROD_W-2 -: MAN_W];
            guard  = s2_prod[PROD_W-2-MAN_W];
            sticky = |s2_prod[PROD_W-3-MAN_W:0];
            e_norm = s2_exp + E_ONE;
        end else begin
            frac_t = s2_prod[PROD_W-3 -: MAN_W];
            guard  = s2_prod[PROD_W-3-MAN_W];
            sticky = |s2_prod[PROD_W-4-MAN_W:0];
            e_norm = s2_exp;
        end
    end

    assign inc      = ~s2_rnd & guard & (sticky | frac_t[0]);
    assign rounded  = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
    assign frac_fin = rounded[MAN_W] ? {MAN_W{1'b0}} : rounded[MAN_W-1:0];
    assign e_fin    = e_norm + (rounded[MAN_W] ? E_ONE : E_ZERO);

    always_comb begin
        res_c   = {s2_sign, e_fin[EXP_W-1:0], frac_fin};
        flags_c = {3'b000, guard | sticky};
        if (s2_spec) begin
            res_c   = s2_spec_res;
            flags_c = s2_spec_flags;
        end else if (e_fin >= E_MAX) begin
            flags_c = 4'b0101;
            if (s2_rnd) begin
                res_c = {s2_sign, {{(EXP_W - 1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
            end else begin
                res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (e_fin <= E_ZERO) begin
            res_c   = {s2_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            flags_c = 4'b0011;
        end
    end

    logic         out_valid_q;
    logic [W-1:0] result_q;
    logic [3:0]   flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            out_valid_q <= s2_valid;
            if (s2_valid) begin
                result_q <= res_c;
                flags_q  <= flags_c;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Testbench for fp_mul_pipe (binary32): vector table plus back-pressure and reset sequences,
// with results checked by a scoreboard queue filled at operand acceptance.
module tb_fp_mul_pipe;
    logic clk;
    logic rst_n;

    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          id;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        rnd;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[21];
    logic [31:0] bp_vals[6];
    int n_compared   = 0;
    int n_mismatched = 0;
    int next_id      = 0;

    task automatic checkOutput(input string name, input int id,
                               input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s (op %0d): got %h, expected %h", name, id, got, want);
        end
    endtask

    // Drives one operand pair and records its expected result once the DUT accepts it.
    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic rm,
                                 input logic [31:0] er, input logic [3:0] ef);
        int waited;
        waited = 0;
        bus.a        = va;
        bus.b        = vb;
        bus.rnd_mode = rm;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL accept_timeout (op %0d): in_ready stuck at 0", next_id);
        end else begin
            sb.push_back('{er, ef, next_id});
            @(posedge clk);
        end
        next_id++;
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Issues one op into an empty, unstalled pipe and measures cycles until out_valid.
    task automatic checkLatency(input string name, input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] er, input logic [3:0] ef);
        int cyc;
        cyc = 0;
        bus.a        = va;
        bus.b        = vb;
        bus.rnd_mode = 1'b0;
        bus.in_valid = 1'b1;
        sb.push_back('{er, ef, next_id});
        next_id++;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) bus.in_valid = 1'b0;
            if (bus.out_valid && cyc == 0) cyc = i;
        end
        checkOutput(name, next_id - 1, 32'(cyc), 32'd3);
    endtask

    task automatic waitDrain(input string name);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 100) begin
            @(posedge clk);
            i++;
        end
        @(posedge clk);
        #1;
        checkOutput(name, -1, 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_output: got %h with nothing outstanding", bus.result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result", e.id, bus.result, e.res);
                checkOutput("flags", e.id, {28'b0, bus.flags}, {28'b0, e.flg});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h40400000, 1'b0, 32'h40400000, 4'h0};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 4'h1};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 4'h1};
        vecs[3]  = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'h5};
        vecs[4]  = '{32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 4'h5};
        vecs[5]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8};
        vecs[6]  = '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8};
        vecs[7]  = '{32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'h3};
        vecs[8]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0};
        vecs[9]  = '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'h0};
        vecs[10] = '{32'h80000000, 32'h40400000, 1'b0, 32'h80000000, 4'h0};
        vecs[11] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h00000000, 4'h0};
        vecs[12] = '{32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 4'h0};
        vecs[13] = '{32'h3FC00001, 32'h3FC00001, 1'b0, 32'h40100002, 4'h1};
        vecs[14] = '{32'h3FC00001, 32'h3FC00001, 1'b1, 32'h40100001, 4'h1};
        vecs[15] = '{32'h3FFFFFFE, 32'h3F800001, 1'b0, 32'h40000000, 4'h1};
        vecs[16] = '{32'h3FFFFFFE, 32'h3F800001, 1'b1, 32'h3FFFFFFF, 4'h1};
        vecs[17] = '{32'h7F7FFFFF, 32'h3F800001, 1'b0, 32'h7F800000, 4'h5};
        vecs[18] = '{32'h7F7FFFFF, 32'h3F800001, 1'b1, 32'h7F7FFFFF, 4'h5};
        vecs[19] = '{32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'h3};
        vecs[20] = '{32'h00800000, 32'h3F800000, 1'b0, 32'h00800000, 4'h0};
        bp_vals  = '{32'h3F800000, 32'h40000000, 32'h40400000,
                     32'h40800000, 32'h40A00000, 32'h40C00000};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.rnd_mode  = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", -1, 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready", -1, 32'(bus.in_ready), 32'd1);
        checkOutput("reset_result", -1, bus.result, 32'h0);
        checkOutput("reset_flags", -1, {28'b0, bus.flags}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] latency check: 1.0 * 3.0");
        checkLatency("latency_first", 32'h3F800000, 32'h40400000, 32'h40400000, 4'h0);
        waitDrain("drain_latency");

        $display("[TB] vector table, back-to-back issue");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].rnd, vecs[i].res, vecs[i].flg);
        end
        waitDrain("drain_table");

        $display("[TB] back-pressure: six ops against a stalled output");
        bus.out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    applyStimulus(32'h3F800000, bp_vals[k], 1'b0, bp_vals[k], 4'h0);
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                checkOutput("bp_in_ready_low", -1, 32'(bus.in_ready), 32'd0);
                checkOutput("bp_out_valid_high", -1, 32'(bus.out_valid), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    checkOutput("bp_result_held", -1, bus.result, 32'h3F800000);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        waitDrain("drain_backpressure");

        $display("[TB] reset with two ops in flight");
        applyStimulus(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'h0);
        applyStimulus(32'h3F800000, 32'h40A00000, 1'b0, 32'h40A00000, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_out_valid", -1, 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("mid_reset_out_valid", -1, 32'(bus.out_valid), 32'd0);
        checkOutput("mid_reset_result", -1, bus.result, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("no_stale_after_reset", -1, 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        checkLatency("latency_after_reset", 32'h40000000, 32'h40400000, 32'h40C00000, 4'h0);
        waitDrain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
